// File: rtl/kb_matrix_scan.sv
// Keyboard matrix scanner: drives one-hot column strobes and samples the row
// lines through a 2-flop synchronizer. A key must read the same value for
// DEBOUNCE_CNT samples before a press or a release is accepted. Each accepted
// press, and each release when REL_EVT=1, is offered to the consumer through a
// single-entry valid/ready event register.
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   k_row           raw row sense lines, active-high
//   k_col           one-hot column strobe
//   key_row/key_col position of the last accepted press
//   key_code        row*COLS+col of the buffered event
//   key_rel         buffered event is a release
//   key_valid       buffered event available; key_ready pops it
//   key_held        a debounced key is currently down
//   ovf             sticky: an event was dropped; ovf_clr clears it
module kb_matrix_scan #(
    parameter int unsigned ROWS         = 5,
    parameter int unsigned COLS         = 4,
    parameter int unsigned SCAN_DIV     = 4,
    parameter int unsigned DEBOUNCE_CNT = 8,
    parameter int unsigned REL_EVT      = 0,
    localparam int unsigned ROW_W  = (ROWS > 1) ? $clog2(ROWS) : 1,
    localparam int unsigned COL_W  = (COLS > 1) ? $clog2(COLS) : 1,
    localparam int unsigned CODE_W = (ROWS * COLS > 1) ? $clog2(ROWS * COLS) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ROWS-1:0]   k_row,
    output logic [COLS-1:0]   k_col,
    output logic [ROW_W-1:0]  key_row,
    output logic [COL_W-1:0]  key_col,
    output logic [CODE_W-1:0] key_code,
    output logic              key_rel,
    output logic              key_valid,
    input  logic              key_ready,
    output logic              key_held,
    output logic              ovf,
    input  logic              ovf_clr
);

    localparam int unsigned DW_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CNT + 1);

    typedef enum logic [1:0] {
        ST_SCAN,
        ST_DEBOUNCE,
        ST_PRESSED
    } state_e;

    state_e              state_q, state_d;
    logic [ROWS-1:0]     rs_meta_q, rs_q;
    logic [COL_W-1:0]    col_q, col_d;
    logic [COLS-1:0]     k_col_q, k_col_d;
    logic [DW_W-1:0]     dwell_q, dwell_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [ROW_W-1:0]    row_cap_q, row_cap_d;
    logic [ROW_W-1:0]    key_row_q, key_row_d;
    logic [COL_W-1:0]    key_col_q, key_col_d;
    logic                held_q, held_d;
    logic [CODE_W-1:0]   code_q, code_d;
    logic                rel_q, rel_d;
    logic                valid_q, valid_d;
    logic                ovf_q, ovf_d;

    logic [ROW_W-1:0]    row_pe_c;
    logic                rs_sel_c;
    logic [COL_W-1:0]    col_next_c;
    logic                push_c;
    logic                push_rel_c;
    logic [CODE_W-1:0]   push_code_c;

    // Row synchronizer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rs_meta_q <= '0;
            rs_q      <= '0;
        end else begin
            rs_meta_q <= k_row;
            rs_q      <= rs_meta_q;
        end
    end

    // Lowest set row wins; the captured row's current level; next column
    always_comb begin
        row_pe_c = '0;
        for (int i = int'(ROWS) - 1; i >= 0; i--) begin
            if (rs_q[i]) row_pe_c = ROW_W'(i);
        end
        rs_sel_c = 1'b0;
        for (int i = 0; i < int'(ROWS); i++) begin
            if (ROW_W'(i) == row_cap_q) rs_sel_c = rs_q[i];
        end
        col_next_c  = (col_q == COL_W'(COLS - 1)) ? '0 : col_q + COL_W'(1);
        push_code_c = CODE_W'(32'(row_cap_q) * COLS + 32'(col_q));
    end

    // Scan / debounce FSM next state
    always_comb begin
        state_d    = state_q;
        col_d      = col_q;
        dwell_d    = dwell_q;
        cnt_d      = cnt_q;
        row_cap_d  = row_cap_q;
        key_row_d  = key_row_q;
        key_col_d  = key_col_q;
        held_d     = held_q;
        push_c     = 1'b0;
        push_rel_c = 1'b0;
        case (state_q)
            ST_SCAN: begin
                if (dwell_q == DW_W'(SCAN_DIV - 1)) begin
                    dwell_d = '0;
                    if (|rs_q) begin
                        row_cap_d = row_pe_c;
                        cnt_d     = '0;
                        state_d   = ST_DEBOUNCE;
                    end else begin
                        col_d = col_next_c;
                    end
                end else begin
                    dwell_d = dwell_q + DW_W'(1);
                end
            end
            ST_DEBOUNCE: begin
                if (rs_sel_c) begin
                    if (cnt_q == CNT_W'(DEBOUNCE_CNT - 1)) begin
                        key_row_d = row_cap_q;
                        key_col_d = col_q;
                        held_d    = 1'b1;
                        push_c    = 1'b1;
                        cnt_d     = '0;
                        state_d   = ST_PRESSED;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end else begin
                    col_d   = col_next_c;
                    dwell_d = '0;
                    state_d = ST_SCAN;
                end
            end
            ST_PRESSED: begin
                // Count consecutive low samples; any high restarts the count
                if (!rs_sel_c) begin
                    if (cnt_q == CNT_W'(DEBOUNCE_CNT - 1)) begin
                        held_d     = 1'b0;
                        push_c     = (REL_EVT != 0);
                        push_rel_c = 1'b1;
                        cnt_d      = '0;
                        col_d      = col_next_c;
                        dwell_d    = '0;
                        state_d    = ST_SCAN;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end else begin
                    cnt_d = '0;
                end
            end
            default: state_d = ST_SCAN;
        endcase
    end

    // Column strobe follows the next column index so it stays registered
    always_comb begin
        k_col_d = '0;
        for (int i = 0; i < int'(COLS); i++) begin
            k_col_d[i] = (COL_W'(i) == col_d);
        end
    end

    // Single-entry event register; a push into a full, unpopped entry is dropped
    always_comb begin
        code_d  = code_q;
        rel_d   = rel_q;
        valid_d = valid_q;
        ovf_d   = ovf_q;
        if (ovf_clr) ovf_d = 1'b0;
        if (valid_q && key_ready) valid_d = 1'b0;
        if (push_c) begin
            if (!valid_q || key_ready) begin
                code_d  = push_code_c;
                rel_d   = push_rel_c;
                valid_d = 1'b1;
            end else begin
                ovf_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_SCAN;
            col_q     <= '0;
            k_col_q   <= COLS'(1);
            dwell_q   <= '0;
            cnt_q     <= '0;
            row_cap_q <= '0;
            key_row_q <= '0;
            key_col_q <= '0;
            held_q    <= 1'b0;
            code_q    <= '0;
            rel_q     <= 1'b0;
            valid_q   <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            col_q     <= col_d;
            k_col_q   <= k_col_d;
            dwell_q   <= dwell_d;
            cnt_q     <= cnt_d;
            row_cap_q <= row_cap_d;
            key_row_q <= key_row_d;
            key_col_q <= key_col_d;
            held_q    <= held_d;
            code_q    <= code_d;
            rel_q     <= rel_d;
            valid_q   <= valid_d;
            ovf_q     <= ovf_d;
        end
    end

    assign k_col     = k_col_q;
    assign key_row   = key_row_q;
    assign key_col   = key_col_q;
    assign key_code  = code_q;
    assign key_rel   = rel_q;
    assign key_valid = valid_q;
    assign key_held  = held_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_kb_matrix_scan.sv
// Bench for kb_matrix_scan: a virtual keypad (pressed[][] matrix) answers the
// column strobes; expected events go into a scoreboard queue when keys are
// pressed/released and a monitor pops and compares whenever an event is taken.
module tb_kb_matrix_scan;

    localparam int ROWS   = 5;
    localparam int COLS   = 4;
    localparam int ROW_W  = 3;
    localparam int COL_W  = 2;
    localparam int CODE_W = 5;

    logic              clk;
    logic              rst_n;
    logic [ROWS-1:0]   k_row;
    logic [COLS-1:0]   k_col;
    logic [ROW_W-1:0]  key_row;
    logic [COL_W-1:0]  key_col;
    logic [CODE_W-1:0] key_code;
    logic              key_rel;
    logic              key_valid;
    logic              key_ready;
    logic              key_held;
    logic              ovf;
    logic              ovf_clr;

    logic [COLS-1:0]   pressed [ROWS];
    int                rdy_mode;
    int                n_tests;
    int                n_fail;

    typedef struct {
        int code;
        int rel;
        int row;
        int col;
        bit chk_pos;
    } exp_t;

    exp_t sb [$];

    kb_matrix_scan #(
        .ROWS(5), .COLS(4), .SCAN_DIV(4), .DEBOUNCE_CNT(8), .REL_EVT(1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .k_row(k_row), .k_col(k_col),
        .key_row(key_row), .key_col(key_col), .key_code(key_code),
        .key_rel(key_rel), .key_valid(key_valid), .key_ready(key_ready),
        .key_held(key_held), .ovf(ovf), .ovf_clr(ovf_clr)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Keypad: a row reads high when a pressed key sits on a driven column
    always_comb begin
        for (int r = 0; r < ROWS; r++) k_row[r] = |(pressed[r] & k_col);
    end

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push_exp(input int r, input int c, input int rel, input bit chk_pos);
        exp_t e;
        e.code = r * COLS + c;
        e.rel = rel;
        e.row = r;
        e.col = c;
        e.chk_pos = chk_pos;
        sb.push_back(e);
    endtask

    task automatic wait_held(input bit v, input int bound, input string name);
        int n;
        n = 0;
        while (key_held !== v && n < bound) begin
            @(negedge clk);
            n++;
        end
        chk(name, int'(key_held), int'(v));
    endtask

    task automatic wait_kcol(input int onehot, input int bound, input string name);
        int n;
        n = 0;
        while (int'(k_col) != onehot && n < bound) begin
            @(negedge clk);
            n++;
        end
        chk(name, int'(k_col), onehot);
    endtask

    task automatic pulse_ready();
        rdy_mode = 2;
        cyc(1);
        rdy_mode = 0;
        cyc(1);
    endtask

    task automatic clear_keys();
        for (int r = 0; r < ROWS; r++) pressed[r] = '0;
    endtask

    // Consumer ready driver
    initial begin
        key_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       key_ready = 1'b0;
                1:       key_ready = ($urandom_range(0, 3) != 0);
                default: key_ready = 1'b1;
            endcase
        end
    end

    // Monitor: every event handed over must match the head of the scoreboard
    initial begin : mon
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && key_valid && key_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_event", int'(key_code), -1);
                end else begin
                    e = sb.pop_front();
                    chk("ev_code", int'(key_code), e.code);
                    chk("ev_rel", int'(key_rel), e.rel);
                    if (e.chk_pos) begin
                        chk("ev_row", int'(key_row), e.row);
                        chk("ev_col", int'(key_col), e.col);
                    end
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int r, c, r2;
        n_tests  = 0;
        n_fail   = 0;
        rdy_mode = 0;
        ovf_clr  = 1'b0;
        rst_n    = 1'b0;
        clear_keys();
        cyc(3);

        // Reset state
        chk("rst_kcol", int'(k_col), 1);
        chk("rst_valid", int'(key_valid), 0);
        chk("rst_held", int'(key_held), 0);
        chk("rst_ovf", int'(ovf), 0);
        chk("rst_code", int'(key_code), 0);
        chk("rst_row", int'(key_row), 0);
        chk("rst_col", int'(key_col), 0);
        chk("rst_rel", int'(key_rel), 0);

        // Idle scan: each column for 4 clocks, wrapping
        rst_n = 1'b1;
        for (int n = 0; n < 20; n++) begin
            chk("kcol_seq", int'(k_col), 1 << ((n / 4) % 4));
            if (n != 19) cyc(1);
        end
        chk("idle_valid", int'(key_valid), 0);
        cyc(1);

        // Press row 2 on column 3, consumer stalled
        pressed[2][3] = 1'b1;
        push_exp(2, 3, 0, 1);
        wait_held(1'b1, 100, "press11_held");
        chk("press11_valid", int'(key_valid), 1);
        chk("press11_code", int'(key_code), 11);
        chk("press11_row", int'(key_row), 2);
        chk("press11_col", int'(key_col), 3);
        chk("press11_kcol", int'(k_col), 8);
        cyc(5);
        chk("press11_frozen", int'(k_col), 8);
        pulse_ready();
        chk("press11_popped", int'(key_valid), 0);

        // Release of the same key
        push_exp(2, 3, 1, 1);
        pressed[2][3] = 1'b0;
        wait_held(1'b0, 50, "rel11_held");
        chk("rel11_valid", int'(key_valid), 1);
        chk("rel11_rel", int'(key_rel), 1);
        chk("rel11_code", int'(key_code), 11);
        chk("rel11_row", int'(key_row), 2);
        pulse_ready();
        chk("rel11_popped", int'(key_valid), 0);

        // Bounce during debounce: 5-cycle pulse on row 1 of column 1
        wait_kcol(2, 40, "bounce_reach_col1");
        pressed[1][1] = 1'b1;
        cyc(5);
        pressed[1][1] = 1'b0;
        wait_kcol(4, 20, "bounce_next_col");
        chk("bounce_valid", int'(key_valid), 0);
        chk("bounce_held", int'(key_held), 0);

        // Overflow: buffer holds code 0, later events are dropped
        pressed[0][0] = 1'b1;
        push_exp(0, 0, 0, 0);
        wait_held(1'b1, 100, "ovf_p0_held");
        pressed[0][0] = 1'b0;
        wait_held(1'b0, 50, "ovf_r0_held");
        pressed[1][1] = 1'b1;
        wait_held(1'b1, 100, "ovf_p5_held");
        pressed[1][1] = 1'b0;
        wait_held(1'b0, 50, "ovf_r5_held");
        chk("ovf_valid", int'(key_valid), 1);
        chk("ovf_code_kept", int'(key_code), 0);
        chk("ovf_set", int'(ovf), 1);
        chk("ovf_row", int'(key_row), 1);
        chk("ovf_col", int'(key_col), 1);
        pulse_ready();
        chk("ovf_popped", int'(key_valid), 0);
        chk("ovf_sticky", int'(ovf), 1);
        ovf_clr = 1'b1;
        cyc(1);
        ovf_clr = 1'b0;
        chk("ovf_cleared", int'(ovf), 0);

        // Rows 0 and 3 on column 1, then reset while held
        rdy_mode = 2;
        pressed[0][1] = 1'b1;
        pressed[3][1] = 1'b1;
        push_exp(0, 1, 0, 1);
        wait_held(1'b1, 100, "multi_held");
        cyc(3);
        chk("multi_drained", sb.size(), 0);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mrst_kcol", int'(k_col), 1);
        chk("mrst_held", int'(key_held), 0);
        chk("mrst_valid", int'(key_valid), 0);
        chk("mrst_code", int'(key_code), 0);
        chk("mrst_row", int'(key_row), 0);
        chk("mrst_col", int'(key_col), 0);
        chk("mrst_ovf", int'(ovf), 0);
        clear_keys();
        @(negedge clk);
        rst_n = 1'b1;
        cyc(2);

        // Randomized keypad activity with a randomly stalling consumer
        rdy_mode = 1;
        for (int it = 0; it < 40; it++) begin
            case ($urandom_range(0, 3))
                0, 1: begin
                    r = $urandom_range(0, ROWS - 1);
                    c = $urandom_range(0, COLS - 1);
                    if ($urandom_range(0, 1) == 1) begin
                        pressed[r][c] = 1'b1;
                        cyc($urandom_range(1, 8));
                        pressed[r][c] = 1'b0;
                        cyc($urandom_range(1, 3));
                    end
                    pressed[r][c] = 1'b1;
                    push_exp(r, c, 0, 1);
                    wait_held(1'b1, 120, "rnd_press_held");
                    cyc($urandom_range(0, 15));
                    if ($urandom_range(0, 1) == 1) begin
                        pressed[r][c] = 1'b0;
                        cyc($urandom_range(1, 7));
                        pressed[r][c] = 1'b1;
                        cyc($urandom_range(2, 10));
                        chk("rnd_rel_bounce_held", int'(key_held), 1);
                    end
                    push_exp(r, c, 1, 1);
                    pressed[r][c] = 1'b0;
                    wait_held(1'b0, 40, "rnd_release_held");
                    cyc($urandom_range(2, 10));
                end
                2: begin
                    c  = $urandom_range(0, COLS - 1);
                    r  = $urandom_range(0, ROWS - 2);
                    r2 = $urandom_range(r + 1, ROWS - 1);
                    pressed[r][c]  = 1'b1;
                    pressed[r2][c] = 1'b1;
                    push_exp(r, c, 0, 1);
                    wait_held(1'b1, 120, "rnd_multi_held");
                    cyc($urandom_range(0, 15));
                    push_exp(r, c, 1, 1);
                    pressed[r][c]  = 1'b0;
                    pressed[r2][c] = 1'b0;
                    wait_held(1'b0, 40, "rnd_multi_release");
                    cyc($urandom_range(2, 10));
                end
                default: begin
                    r = $urandom_range(0, ROWS - 1);
                    c = $urandom_range(0, COLS - 1);
                    pressed[r][c] = 1'b1;
                    cyc($urandom_range(1, 8));
                    pressed[r][c] = 1'b0;
                    cyc(20);
                    chk("rnd_glitch_held", int'(key_held), 0);
                end
            endcase
        end

        rdy_mode = 2;
        cyc(10);
        chk("end_sb_empty", sb.size(), 0);
        chk("end_ovf", int'(ovf), 0);
        chk("end_held", int'(key_held), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
